// File: rtl/nn_pkg.sv
// Shared types and constants for the neuron training controller and its loss stages.
package nn_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FWD,
        BSETUP,
        BWD,
        DONE
    } state_t;

    localparam logic [1:0] PH_FSETUP = 2'b00;
    localparam logic [1:0] PH_FWD    = 2'b10;
    localparam logic [1:0] PH_BSETUP = 2'b11;
    localparam logic [1:0] PH_BWD    = 2'b01;

    localparam logic [15:0] Q88_ONE = 16'h0100;
    localparam logic [15:0] Q88_MAX = 16'h7FFF;
    localparam logic [15:0] Q88_MIN = 16'h8000;

endpackage

// File: rtl/fxp_sat_sub.sv
// Combinational signed saturating subtract diff_o = sat(a_i - b_i), BITS wide.
module fxp_sat_sub #(
    parameter int BITS = 16
) (
    input  logic [BITS-1:0] a_i,
    input  logic [BITS-1:0] b_i,
    output logic [BITS-1:0] diff_o
);

    logic [BITS:0] wide;

    assign wide = {a_i[BITS-1], a_i} - {b_i[BITS-1], b_i};

    // Overflow iff the guard bit disagrees with the result sign; the guard bit is the true sign.
    always_comb begin
        diff_o = wide[BITS-1:0];
        if (wide[BITS] != wide[BITS-1]) begin
            diff_o = wide[BITS] ? {1'b1, {(BITS-1){1'b0}}} : {1'b0, {(BITS-1){1'b1}}};
        end
    end

endmodule

// File: rtl/neuron_train_ctrl.sv
// Sequences one forward/backward training step of a ReLU neuron and captures its results.
module neuron_train_ctrl
    import nn_pkg::*;
#(
    parameter int N          = 6,
    parameter int BITS       = 16,
    parameter int FWD_CYCLES = 8,
    parameter int BWD_CYCLES = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [BITS-1:0]       target,
    input  logic [BITS-1:0]       y,
    input  logic [(N+1)*BITS-1:0] W_out,
    output logic                  FP,
    output logic                  BP,
    output logic [BITS-1:0]       dZ_in,
    output logic [BITS-1:0]       W_in,
    output logic                  busy,
    output logic                  done,
    output logic [BITS-1:0]       y_q,
    output logic [BITS-1:0]       err_q,
    output logic [(N+1)*BITS-1:0] w_q,
    output logic [15:0]           iter_cnt
);

    localparam int CMAX = (FWD_CYCLES > BWD_CYCLES) ? FWD_CYCLES : BWD_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);

    state_t                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [BITS-1:0]         tgt_q, tgt_d;
    logic [BITS-1:0]         y_d, err_d, dz_q, dz_d, sub_res;
    logic [(N+1)*BITS-1:0]   w_d;
    logic [15:0]             iter_q, iter_d;
    logic [1:0]              ph_q, ph_d;
    logic                    busy_q, busy_d, done_q, done_d;

    fxp_sat_sub #(.BITS(BITS)) u_sub (
        .a_i   (y),
        .b_i   (tgt_q),
        .diff_o(sub_res)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tgt_d   = tgt_q;
        y_d     = y_q;
        err_d   = err_q;
        w_d     = w_q;
        iter_d  = iter_q;
        case (state_q)
            IDLE: if (start) begin
                state_d = FWD;
                tgt_d   = target;
                cnt_d   = '0;
            end
            FWD: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(FWD_CYCLES - 1)) begin
                    state_d = BSETUP;
                    y_d     = y;
                    err_d   = sub_res;
                end
            end
            BSETUP: begin
                state_d = BWD;
                cnt_d   = '0;
            end
            BWD: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(BWD_CYCLES - 1)) begin
                    state_d = DONE;
                    w_d     = W_out;
                end
            end
            DONE: begin
                state_d = IDLE;
                iter_d  = iter_q + 16'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they leave the flops aligned with the state.
    always_comb begin
        case (state_d)
            FWD:     ph_d = PH_FWD;
            BSETUP:  ph_d = PH_BSETUP;
            BWD:     ph_d = PH_BWD;
            default: ph_d = PH_FSETUP;
        endcase
        dz_d   = (state_d == BSETUP || state_d == BWD) ? err_d : '0;
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            tgt_q   <= '0;
            y_q     <= '0;
            err_q   <= '0;
            w_q     <= '0;
            iter_q  <= '0;
            ph_q    <= PH_FSETUP;
            dz_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tgt_q   <= tgt_d;
            y_q     <= y_d;
            err_q   <= err_d;
            w_q     <= w_d;
            iter_q  <= iter_d;
            ph_q    <= ph_d;
            dz_q    <= dz_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign FP       = ph_q[1];
    assign BP       = ph_q[0];
    assign dZ_in    = dz_q;
    assign W_in     = BITS'(Q88_ONE);
    assign busy     = busy_q;
    assign done     = done_q;
    assign iter_cnt = iter_q;

endmodule
